// File: rtl/det_event_logger_pkg.sv
// Shared types, default widths and helpers for the detector event logger.
package det_pkg;

  localparam int GAP_W_DEF = 8;
  localparam int SEQ_W_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;

  // Record layout at the default widths; the FIFO payload packs gap above seq.
  typedef struct packed {
    logic [GAP_W_DEF-1:0] gap;
    logic [SEQ_W_DEF-1:0] seq;
  } det_evt_t;

  // Saturating increment of a w-bit quantity carried in 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/det_event_logger_if.sv
// Valid/ready record stream from the event logger to the host/monitor.
interface det_event_logger_if
  import det_pkg::*;
#(
  parameter int GAP_W = GAP_W_DEF,
  parameter int SEQ_W = SEQ_W_DEF
);
  logic             out_valid;
  logic             out_ready;
  logic [GAP_W-1:0] out_gap;
  logic [SEQ_W-1:0] out_seq;

  modport master (output out_valid, output out_gap, output out_seq, input  out_ready);
  modport slave  (input  out_valid, input  out_gap, input  out_seq, output out_ready);
endinterface

// File: rtl/det_event_logger_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module det_evt_fifo
  import det_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = GAP_W_DEF + SEQ_W_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/det_event_logger.sv
// Converts qualified detector verdicts into {gap, seq} records, buffers them and counts drops.
module det_event_logger
  import det_pkg::*;
#(
  parameter int GAP_W = GAP_W_DEF,
  parameter int SEQ_W = SEQ_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               bit_valid,
  input  logic               detect,
  input  logic               clear,
  det_event_logger_if.master out_if,
  output logic [CNT_W-1:0]   total_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               overflow
);
  localparam int PW = GAP_W + SEQ_W;

  logic             bv_d_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [SEQ_W-1:0] seq_cnt_reg;
  logic [CNT_W-1:0] total_cnt_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic             overflow_reg;

  logic          evt;
  logic          pop;
  logic          accept;
  logic          fifo_full;
  logic          fifo_empty;
  logic [PW-1:0] fifo_dout;

  // detect is updated on the bit_valid edge, so pairing it with the delayed
  // strobe samples exactly one verdict per consumed bit.
  assign evt    = bv_d_reg && detect;
  assign pop    = !fifo_empty && out_if.out_ready;
  assign accept = evt && (!fifo_full || pop);

  det_evt_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .push  (accept),
    .pop   (pop),
    .din   ({gap_cnt_reg, seq_cnt_reg}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_gap   = fifo_dout[PW-1:SEQ_W];
  assign out_if.out_seq   = fifo_dout[SEQ_W-1:0];

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      bv_d_reg      <= 1'b0;
      gap_cnt_reg   <= '0;
      seq_cnt_reg   <= '0;
      total_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      bv_d_reg <= bit_valid;
      if (evt) begin
        // The triggering bit was already counted; a bit arriving now starts the next gap.
        gap_cnt_reg   <= bit_valid ? GAP_W'(1) : '0;
        seq_cnt_reg   <= seq_cnt_reg + 1'b1;
        total_cnt_reg <= CNT_W'(sat_inc(32'(total_cnt_reg), CNT_W));
        if (!accept) begin
          drop_cnt_reg <= CNT_W'(sat_inc(32'(drop_cnt_reg), CNT_W));
          overflow_reg <= 1'b1;
        end
      end else if (bit_valid) begin
        gap_cnt_reg <= GAP_W'(sat_inc(32'(gap_cnt_reg), GAP_W));
      end
    end
  end

  assign total_cnt = total_cnt_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign overflow  = overflow_reg;
endmodule

// File: tb/tb_det_event_logger.sv
// Directed bench for det_event_logger: one task per scenario, inline checks.
module tb_det_event_logger;
  import det_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        bit_valid;
  logic        detect;
  logic        clear;
  logic [15:0] total_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  det_evt_t got_q[$];
  det_evt_t mon_rec;

  det_event_logger_if #(.GAP_W(8), .SEQ_W(4)) dif ();

  det_event_logger #(.GAP_W(8), .SEQ_W(4), .CNT_W(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bit_valid (bit_valid),
    .detect    (detect),
    .clear     (clear),
    .out_if    (dif),
    .total_cnt (total_cnt),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Record every handshake that will complete on the coming posedge.
  always @(negedge clk) begin
    if (rstn && !clear && dif.out_valid && dif.out_ready) begin
      mon_rec.gap = dif.out_gap;
      mon_rec.seq = dif.out_seq;
      got_q.push_back(mon_rec);
      $display("pop: gap=%0d seq=%0d", dif.out_gap, dif.out_seq);
    end
  end

  task automatic step(input logic bv, input logic det);
    bit_valid = bv;
    detect    = det;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; bit_valid = 1'b0; detect = 1'b0; clear = 1'b0; dif.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    got_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", dif.out_valid); end
    n_cmp++; if (dif.out_gap !== 8'd0) begin n_bad++; $display("FAIL reset_gap: got %0d want 0", dif.out_gap); end
    n_cmp++; if (dif.out_seq !== 4'd0) begin n_bad++; $display("FAIL reset_seq: got %0d want 0", dif.out_seq); end
    n_cmp++; if (total_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_total: got %0d want 0", total_cnt); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    // Reset with a record buffered discards it.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    n_cmp++; if (dif.out_valid !== 1'b1) begin n_bad++; $display("FAIL midreset_pre_valid: got %0b want 1", dif.out_valid); end
    rstn = 1'b0;
    step(1'b0, 1'b0);
    rstn = 1'b1;
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %0b want 0", dif.out_valid); end
    n_cmp++; if (total_cnt !== 16'd0) begin n_bad++; $display("FAIL midreset_total: got %0d want 0", total_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_single_pattern();
    do_reset();
    dif.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %0b want 0", dif.out_valid); end
    step(1'b0, 1'b1);
    n_cmp++; if (dif.out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %0b want 1", dif.out_valid); end
    n_cmp++; if (dif.out_gap !== 8'd5) begin n_bad++; $display("FAIL single_gap: got %0d want 5", dif.out_gap); end
    n_cmp++; if (dif.out_seq !== 4'd0) begin n_bad++; $display("FAIL single_seq: got %0d want 0", dif.out_seq); end
    n_cmp++; if (total_cnt !== 16'd1) begin n_bad++; $display("FAIL single_total: got %0d want 1", total_cnt); end
    step(1'b0, 1'b0);
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drained: got %0b want 0", dif.out_valid); end
    n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    $display("test_single_pattern done");
  endtask

  task automatic test_overlap();
    do_reset();
    dif.out_ready = 1'b1;
    // 1011010110 one bit per cycle; detect follows the 5th and 10th bits.
    for (int c = 0; c <= 10; c++) step(c < 10, (c == 5) || (c == 10));
    step(1'b0, 1'b0);
    n_cmp++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL overlap_count: got %0d want 2", got_q.size()); end
    n_cmp++; if (got_q[0].gap !== 8'd5 || got_q[0].seq !== 4'd0) begin n_bad++; $display("FAIL overlap_rec0: got gap=%0d seq=%0d want gap=5 seq=0", got_q[0].gap, got_q[0].seq); end
    n_cmp++; if (got_q[1].gap !== 8'd5 || got_q[1].seq !== 4'd1) begin n_bad++; $display("FAIL overlap_rec1: got gap=%0d seq=%0d want gap=5 seq=1", got_q[1].gap, got_q[1].seq); end
    n_cmp++; if (total_cnt !== 16'd2) begin n_bad++; $display("FAIL overlap_total: got %0d want 2", total_cnt); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL overlap_drop: got %0d want 0", drop_cnt); end
    $display("test_overlap done");
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int e = 0; e < 6; e++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      n_cmp++; if (dif.out_valid !== 1'b1 || dif.out_seq !== 4'd0) begin n_bad++; $display("FAIL full_head_hold%0d: got valid=%0b seq=%0d want valid=1 seq=0", e, dif.out_valid, dif.out_seq); end
    end
    n_cmp++; if (total_cnt !== 16'd6) begin n_bad++; $display("FAIL full_total: got %0d want 6", total_cnt); end
    n_cmp++; if (drop_cnt !== 16'd2) begin n_bad++; $display("FAIL full_drop: got %0d want 2", drop_cnt); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL full_ovf: got %0b want 1", overflow); end
    dif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    n_cmp++; if (got_q.size() !== 4) begin n_bad++; $display("FAIL full_drain_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got_q[i].seq !== 4'(i) || got_q[i].gap !== 8'd1) begin n_bad++; $display("FAIL full_order%0d: got gap=%0d seq=%0d want gap=1 seq=%0d", i, got_q[i].gap, got_q[i].seq, i); end
    end
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty: got %0b want 0", dif.out_valid); end
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    n_cmp++; if (dif.out_seq !== 4'd6) begin n_bad++; $display("FAIL full_next_seq: got %0d want 6", dif.out_seq); end
    $display("test_fifo_full done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int e = 0; e < 4; e++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
    end
    step(1'b1, 1'b0);
    dif.out_ready = 1'b1;
    step(1'b0, 1'b1);
    dif.out_ready = 1'b0;
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL b2b_drop: got %0d want 0", drop_cnt); end
    n_cmp++; if (dif.out_seq !== 4'd1) begin n_bad++; $display("FAIL b2b_head: got %0d want 1", dif.out_seq); end
    n_cmp++; if (total_cnt !== 16'd5) begin n_bad++; $display("FAIL b2b_total: got %0d want 5", total_cnt); end
    // Occupancy is still 4, so the next event must be dropped.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    n_cmp++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL b2b_still_full: got %0d want 1", drop_cnt); end
    dif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    n_cmp++; if (got_q.size() !== 5) begin n_bad++; $display("FAIL b2b_count: got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (got_q[i].seq !== 4'(i)) begin n_bad++; $display("FAIL b2b_order%0d: got %0d want %0d", i, got_q[i].seq, i); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_detect_hold();
    do_reset();
    dif.out_ready = 1'b1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    n_cmp++; if (total_cnt !== 16'd1) begin n_bad++; $display("FAIL hold_total: got %0d want 1", total_cnt); end
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    n_cmp++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL hold_count: got %0d want 2", got_q.size()); end
    n_cmp++; if (got_q[0].gap !== 8'd1) begin n_bad++; $display("FAIL hold_gap0: got %0d want 1", got_q[0].gap); end
    n_cmp++; if (got_q[1].gap !== 8'd255 || got_q[1].seq !== 4'd1) begin n_bad++; $display("FAIL sat_gap: got gap=%0d seq=%0d want gap=255 seq=1", got_q[1].gap, got_q[1].seq); end
    $display("test_detect_hold done");
  endtask

  task automatic test_clear();
    do_reset();
    for (int e = 0; e < 5; e++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
    end
    dif.out_ready = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    dif.out_ready = 1'b0;
    n_cmp++; if (dif.out_seq !== 4'd2 || overflow !== 1'b1) begin n_bad++; $display("FAIL clear_pre: got seq=%0d ovf=%0b want seq=2 ovf=1", dif.out_seq, overflow); end
    clear = 1'b1;
    step(1'b1, 1'b0);
    clear = 1'b0;
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL clear_valid: got %0b want 0", dif.out_valid); end
    n_cmp++; if (total_cnt !== 16'd0 || drop_cnt !== 16'd0) begin n_bad++; $display("FAIL clear_cnts: got total=%0d drop=%0d want 0/0", total_cnt, drop_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clear_ovf: got %0b want 0", overflow); end
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    n_cmp++; if (dif.out_seq !== 4'd0 || dif.out_gap !== 8'd1) begin n_bad++; $display("FAIL clear_next: got gap=%0d seq=%0d want gap=1 seq=0", dif.out_gap, dif.out_seq); end
    $display("test_clear done");
  endtask

  initial begin
    rstn = 1'b0; bit_valid = 1'b0; detect = 1'b0; clear = 1'b0; dif.out_ready = 1'b0;
    test_reset();
    test_single_pattern();
    test_overlap();
    test_fifo_full();
    test_back_to_back();
    test_detect_hold();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/det_event_logger.md
Name: det_event_logger

Overview:
- Downstream stage of the dynamic pattern detector.
- Takes the detector's per-bit strobe and its registered detect flag. Turns each qualified detection into an event record: the gap in bits since the previous event, plus a sequence number.
- Buffers records in a small FIFO that drains over a valid/ready interface to the host/monitor.
- Keeps saturating total and drop counters and a sticky overflow flag.

Parameters:
- GAP_W, 8, width of the bit-gap field; gap counter saturates at 2^GAP_W-1.
- SEQ_W, 4, width of the event sequence number; wraps modulo 2^SEQ_W.
- CNT_W, 16, width of total_cnt and drop_cnt; both saturate at all-ones.
- DEPTH, 4, FIFO depth in records; power of two, >=2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  synchronous active-low reset.
- bit_valid  in  1  same strobe that drives the detector's valid; one serial bit consumed per high cycle.
- detect  in  1  detector's registered detect output.
- clear  in  1  synchronous soft clear.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record when out_valid&&out_ready.
- out_gap  out  GAP_W  gap field of the head record.
- out_seq  out  SEQ_W  sequence field of the head record.
- total_cnt  out  CNT_W  events detected, including dropped ones.
- drop_cnt  out  CNT_W  events lost because the FIFO was full.
- overflow  out  1  sticky; set on the first drop.

Behaviour:
- Reset (rstn=0 at posedge) clears everything: out_valid=0, out_gap=0, out_seq=0, total_cnt=0, drop_cnt=0, overflow=0; FIFO empty, gap_cnt=0, seq_cnt=0, bv_d=0. Reset mid-stream discards buffered records with no output.
- clear=1 (rstn=1) has the same effect as reset. It takes priority over every event and pop in that cycle.
- bv_d: register of bit_valid.
- Event: a cycle where bv_d==1 && detect==1. The detector updates detect on the valid edge, so this samples exactly one verdict per consumed bit.
  - A detect held high across cycles without a new bit_valid does not re-fire.
  - Back-to-back overlapping detections fire once per bit.
- gap_cnt: +1 on every bit_valid, saturating. On an event cycle:
  - The recorded gap is the current gap_cnt, i.e. bits since the previous event, including the triggering bit.
  - gap_cnt then reloads to 1 if bit_valid is also high that cycle, else 0.
- seq_cnt: the record carries the current seq_cnt, which then increments (wrap) on every event, accepted or dropped. A missing number downstream therefore reveals a drop.
- total_cnt: +1 per event, saturating.
- Push: the event is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Drop: otherwise the event is dropped; drop_cnt +1 (saturating) and overflow<=1. overflow clears only on reset or clear.
- FIFO:
  - First-word fall-through; out_valid = !empty. out_gap/out_seq show the head and hold stable while out_valid&&!out_ready.
  - A push into an empty FIFO is visible (out_valid=1) the next cycle: one-cycle latency event→out_valid.
  - Simultaneous push and pop at any occupancy: occupancy unchanged, order preserved.
  - Pop when empty has no effect. Read/write pointers wrap modulo DEPTH.
  - Occupancy uses a log2(DEPTH)+1-bit counter.
- Overall latency: the bit that completes the pattern is on bit_valid at cycle N, detect rises at N+1, the event is sampled at N+1, and out_valid rises at N+2.

Decomposition:
- Package det_pkg holds:
  - typedef det_evt_t, a packed struct {gap[GAP_W], seq[SEQ_W]};
  - default width constants;
  - a sat_inc function for saturating increment.
- One sub-module, det_evt_fifo: synchronous FWFT FIFO parameterised on DEPTH and payload width, with push/pop/full/empty/clear.
- Event qualification, counters and drop logic stay in the top module.

Test Plan:
- Pattern 10110 fed one bit per cycle after reset, out_ready=1 → exactly one record {gap=5, seq=0}; out_valid rises two cycles after the last bit's bit_valid; total_cnt=1.
- Overlap stream 1011010110 (detector overlap mode), bit_valid every cycle → records {gap=5, seq=0} then {gap=5, seq=1}; total_cnt=2, drop_cnt=0.
- out_ready=0, 6 events → FIFO holds seq 0..3 with out_seq=0 stable. Then out_ready=1 → pops seq 0,1,2,3 in order. Results: drop_cnt=2, overflow=1, total_cnt=6, seq_cnt=6.
- FIFO full, event coincident with a pop → no drop; occupancy stays at 4; drop_cnt unchanged.
- detect held high 3 cycles with bit_valid low → only one event; 300 bits with no event, then an event → gap=255 (saturated).
- Assert clear with 2 records buffered and overflow=1 → next cycle: out_valid=0, all counters 0, overflow=0; next event has seq=0.
